// File: rtl/my_top_level_pkg.sv
// Shared constants and types for the my_top_level registered adder.
`default_nettype none

package my_top_level_pkg;

  localparam int ADD_WIDTH       = 8;
  localparam int MAX_PIPE_STAGES = 4;

  // {carry, sum} word held by each pipeline stage at the default width.
  typedef logic [ADD_WIDTH:0] stage_word_t;

  function automatic int clamp_stages(input int stages);
    if (stages < 1) return 1;
    if (stages > MAX_PIPE_STAGES) return MAX_PIPE_STAGES;
    return stages;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_pipe_stage.sv
// One {carry, sum} pipeline register with asynchronous active-low clear.
`default_nettype none

module add_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
    end else begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

`default_nettype wire

// File: rtl/my_top_level.sv
// Registered unsigned adder with PIPE_STAGES output registers.
// Build option: MY_TOP_LEVEL_SATURATE_EN clamps overflowing sums to all-ones.
`default_nettype none

module my_top_level
  import my_top_level_pkg::*;
#(
  parameter int WIDTH       = ADD_WIDTH,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  output logic [WIDTH-1:0] io_X,
  output logic             io_C
);

  localparam int STAGES = clamp_stages(PIPE_STAGES);

  logic [WIDTH:0] sum_d;
  logic [WIDTH:0] stage_d;
  logic [STAGES:0][WIDTH:0] chain;

  assign sum_d = {1'b0, io_A} + {1'b0, io_B};

`ifdef MY_TOP_LEVEL_SATURATE_EN
  // Carry is kept raw; only the sum field saturates.
  assign stage_d = sum_d[WIDTH] ? {1'b1, {WIDTH{1'b1}}} : sum_d;
`else
  assign stage_d = sum_d;
`endif

  assign chain[0] = stage_d;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    add_pipe_stage #(
      .W (WIDTH + 1)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .d_i   (chain[i]),
      .q_o   (chain[i+1])
    );
  end

  assign io_X = chain[STAGES][WIDTH-1:0];
  assign io_C = chain[STAGES][WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_my_top_level.sv
// Self-checking bench for my_top_level against a queue-based sum model.
`default_nettype none

module tb_my_top_level;

  localparam int W    = 8;
  localparam int PIPE = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] io_A;
  logic [W-1:0] io_B;
  logic [W-1:0] io_X;
  logic         io_C;

  int checks   = 0;
  int failures = 0;

  // Expected {carry, sum} results in flight; front is what io_X shows.
  int exp_q[$];
  logic [W-1:0] exp_x;
  logic         exp_c;

  my_top_level #(
    .WIDTH       (W),
    .PIPE_STAGES (PIPE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_A  (io_A),
    .io_B  (io_B),
    .io_X  (io_X),
    .io_C  (io_C)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_result(input int a, input int b);
    int s;
    int lim;
    lim = 1 << W;
    s = a + b;
`ifdef MY_TOP_LEVEL_SATURATE_EN
    if (s >= lim) return lim + (lim - 1);
`endif
    return s;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < PIPE; i++) exp_q.push_back(0);
    exp_x = '0;
    exp_c = 1'b0;
  endtask

  // Drive one operand pair, clock it in, advance the model, settle.
  task automatic cycle(input int a, input int b);
    int r;
    @(negedge clk);
    io_A = W'(a);
    io_B = W'(b);
    @(posedge clk);
    exp_q.push_back(ref_result(a, b));
    void'(exp_q.pop_front());
    r = exp_q[0];
    exp_x = W'(r % (1 << W));
    exp_c = (r >= (1 << W));
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    io_A  = 8'h12;
    io_B  = 8'h34;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (io_X !== 8'h00 || io_C !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: got X=%h C=%b want X=00 C=0", io_X, io_C);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < PIPE; i++) begin
      cycle(8'h12, 8'h34);
    end
    checks++;
    if (io_X !== 8'h46 || io_C !== 1'b0) begin
      failures++;
      $display("FAIL reset_prefill: got X=%h C=%b want X=46 C=0", io_X, io_C);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (io_X !== 8'h00 || io_C !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got X=%h C=%b want X=00 C=0", io_X, io_C);
    end
    model_clear();
    io_A = '0;
    io_B = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle_zero();
    for (int i = 0; i < PIPE + 1; i++) begin
      cycle(0, 0);
      checks++;
      if (io_X !== 8'h00 || io_C !== 1'b0) begin
        failures++;
        $display("FAIL idle_zero: got X=%h C=%b want X=00 C=0", io_X, io_C);
      end
    end
  endtask

  task automatic test_basic_add();
    cycle(3, 5);
    for (int i = 1; i < PIPE; i++) begin
      checks++;
      if (io_X !== 8'h00) begin
        failures++;
        $display("FAIL latency_early: got X=%h want X=00 at stage %0d", io_X, i);
      end
      cycle(0, 0);
    end
    checks++;
    if (io_X !== 8'h08 || io_C !== 1'b0) begin
      failures++;
      $display("FAIL basic_add: got X=%h C=%b want X=08 C=0", io_X, io_C);
    end
  endtask

  task automatic test_overflow();
    int pairs_a[3] = '{8'hFF, 8'h80, 8'hF0};
    int pairs_b[3] = '{8'h01, 8'h7F, 8'h20};
    for (int i = 0; i < 3 + PIPE; i++) begin
      if (i < 3) cycle(pairs_a[i], pairs_b[i]);
      else cycle(0, 0);
      checks++;
      if (io_X !== exp_x || io_C !== exp_c) begin
        failures++;
        $display("FAIL overflow[%0d]: got X=%h C=%b want X=%h C=%b", i, io_X, io_C, exp_x, exp_c);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sa[4]         = '{1, 2, 200, 0};
    int sb[4]         = '{1, 2, 100, 0};
    logic [7:0] wx[4] = '{8'h02, 8'h04, 8'h2C, 8'h00};
    logic       wc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4 + PIPE - 1; i++) begin
      if (i < 4) cycle(sa[i], sb[i]);
      else cycle(0, 0);
      if (i >= PIPE - 1) begin
        checks++;
        if (io_X !== wx[i-PIPE+1] || io_C !== wc[i-PIPE+1]) begin
          failures++;
          $display("FAIL back_to_back[%0d]: got X=%h C=%b want X=%h C=%b",
                   i - PIPE + 1, io_X, io_C, wx[i-PIPE+1], wc[i-PIPE+1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      cycle(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      checks++;
      if (io_X !== exp_x || io_C !== exp_c) begin
        failures++;
        $display("FAIL random[%0d]: got X=%h C=%b want X=%h C=%b", i, io_X, io_C, exp_x, exp_c);
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(8'h11, 8'h22);
    cycle(8'hC0, 8'h44);
    checks++;
    if (io_X !== exp_x || io_C !== exp_c) begin
      failures++;
      $display("FAIL midstream_pre: got X=%h C=%b want X=%h C=%b", io_X, io_C, exp_x, exp_c);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (io_X !== 8'h00 || io_C !== 1'b0) begin
      failures++;
      $display("FAIL midstream_clear: got X=%h C=%b want X=00 C=0", io_X, io_C);
    end
    model_clear();
    io_A = '0;
    io_B = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (io_X !== 8'h00 || io_C !== 1'b0) begin
      failures++;
      $display("FAIL midstream_release: got X=%h C=%b want X=00 C=0", io_X, io_C);
    end
    cycle(5, 6);
    for (int i = 0; i < PIPE; i++) begin
      checks++;
      if (io_X !== exp_x || io_C !== exp_c) begin
        failures++;
        $display("FAIL midstream_post[%0d]: got X=%h C=%b want X=%h C=%b", i, io_X, io_C, exp_x, exp_c);
      end
      cycle(0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_idle_zero();
    test_basic_add();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
